ahbl_sst26_xip_rd: RTL and testbench

- AHB-Lite slave providing execute-in-place read access to the external SST26VF080A serial flash.
- Sits directly downstream of the core's AHB-Lite master port, behind the address decoder (HSEL).
- Converts each word read into a single-bit SPI READ (0x03) transaction.
- A one-entry last-word buffer gives zero-wait hits for repeated fetches of the same word.

---
 rtl/ahbl_sst26_xip_rd_if.sv | 22 ++
 rtl/ahbl_sst26_xip_rd.sv | 143 ++++++++++++++
 tb/tb_ahbl_sst26_xip_rd.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_sst26_xip_rd_if.sv
// AHB-Lite bus bundle for the SST26 execute-in-place read slave.
interface ahbl_sst26_xip_rd_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahbl_sst26_xip_rd.sv
// AHB-Lite read-only XIP slave: each word miss becomes one SPI READ (0x03) frame to the
// SST26 flash; a one-entry last-word buffer serves repeated fetches with zero wait states.
module ahbl_sst26_xip_rd #(
  parameter int unsigned SCK_DIV     = 1,
  parameter int unsigned CS_HIGH_CYC = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahbl_sst26_xip_rd_if.slave     bus,
  output logic                   fsclk,
  output logic                   fcen,
  output logic                   fdo,
  input  logic                   fdi
);

  localparam logic [4:0] HalfM1 = 5'(SCK_DIV - 1);
  localparam logic [4:0] FullM1 = 5'(2 * SCK_DIV - 1);
  localparam logic [3:0] GapMin = 4'(CS_HIGH_CYC);

  typedef enum logic [2:0] {StIdle, StGap, StCsLow, StShift, StDone} state_e;

  state_e      state_q;
  logic        fsclk_q, fcen_q, fdo_q, hready_q;
  logic [31:0] hrdata_q;
  logic        buf_valid_q;
  logic [17:0] buf_tag_q;
  logic [31:0] buf_data_q;
  logic [17:0] waddr_q;
  logic [63:0] frame_q;
  logic [31:0] rx_q;
  logic [4:0]  div_q;
  logic [5:0]  bit_q;
  logic [3:0]  gap_q;

  logic [17:0] waddr_in;
  logic        rd_accept, hit, gap_ok, bit_end;
  logic [63:0] frame_in;
  logic [31:0] rx_next, rx_word;
  logic        unused_ok;

  always_comb begin
    waddr_in  = bus.HADDR[19:2];
    rd_accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] && !bus.HWRITE &&
                (state_q == StIdle || state_q == StDone);
    hit       = buf_valid_q && (buf_tag_q == waddr_in);
    gap_ok    = (gap_q >= GapMin);
    frame_in  = {8'h03, 4'h0, waddr_in, 2'b00, 32'h0};
    bit_end   = (div_q == FullM1);
    rx_next   = {rx_q[30:0], fdi};
    // Bytes arrive B0 first; B0 belongs at the lowest address (little-endian word).
    rx_word   = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    unused_ok = ^{bus.HSIZE, bus.HADDR[31:20], bus.HADDR[1:0], bus.HTRANS[0]};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      fsclk_q     <= 1'b0;
      fcen_q      <= 1'b1;
      fdo_q       <= 1'b0;
      hready_q    <= 1'b1;
      hrdata_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      waddr_q     <= '0;
      frame_q     <= '0;
      rx_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
    end else begin
      if (fcen_q && gap_q != 4'hf) gap_q <= gap_q + 4'd1;
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          if (rd_accept) begin
            if (hit) begin
              hrdata_q <= buf_data_q;
            end else begin
              waddr_q  <= waddr_in;
              frame_q  <= frame_in;
              hready_q <= 1'b0;
              if (gap_ok) begin
                state_q <= StCsLow;
                fcen_q  <= 1'b0;
                fdo_q   <= frame_in[63];
              end else begin
                state_q <= StGap;
              end
            end
          end
        end
        StGap: begin
          if (gap_ok) begin
            state_q <= StCsLow;
            fcen_q  <= 1'b0;
            fdo_q   <= frame_q[63];
          end
        end
        StCsLow: begin
          state_q <= StShift;
          div_q   <= '0;
          bit_q   <= '0;
          fsclk_q <= 1'b0;
        end
        StShift: begin
          if (div_q == HalfM1) fsclk_q <= 1'b1;
          if (bit_end) begin
            div_q   <= '0;
            bit_q   <= bit_q + 6'd1;
            fsclk_q <= 1'b0;
            rx_q    <= rx_next;
            frame_q <= {frame_q[62:0], 1'b0};
            fdo_q   <= frame_q[62];
            if (bit_q == 6'd63) begin
              state_q     <= StDone;
              fcen_q      <= 1'b1;
              fdo_q       <= 1'b0;
              hready_q    <= 1'b1;
              hrdata_q    <= rx_word;
              buf_data_q  <= rx_word;
              buf_tag_q   <= waddr_q;
              buf_valid_q <= 1'b1;
              gap_q       <= '0;
            end
          end else begin
            div_q <= div_q + 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = 1'b0;
  assign fsclk         = fsclk_q;
  assign fcen          = fcen_q;
  assign fdo           = fdo_q;

endmodule

// File: tb/tb_ahbl_sst26_xip_rd.sv
// Directed bench: two slaves (SCK_DIV=1 and SCK_DIV=3), each with a behavioural SST26 read model.
module tb_ahbl_sst26_xip_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic sel1, sel3, hwrite;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic fsclk1, fcen1, fdo1, fdi1;
  logic fsclk3, fcen3, fdo3, fdi3;

  ahbl_sst26_xip_rd_if b1();
  ahbl_sst26_xip_rd_if b3();

  assign b1.HSEL   = sel1;
  assign b1.HADDR  = haddr;
  assign b1.HTRANS = htrans;
  assign b1.HSIZE  = hsize;
  assign b1.HWRITE = hwrite;
  assign b1.HREADY = b1.HREADYOUT;
  assign b3.HSEL   = sel3;
  assign b3.HADDR  = haddr;
  assign b3.HTRANS = htrans;
  assign b3.HSIZE  = hsize;
  assign b3.HWRITE = hwrite;
  assign b3.HREADY = b3.HREADYOUT;

  ahbl_sst26_xip_rd #(.SCK_DIV(1), .CS_HIGH_CYC(2)) dut1 (
    .HCLK(clk), .HRESETn(rstn), .bus(b1),
    .fsclk(fsclk1), .fcen(fcen1), .fdo(fdo1), .fdi(fdi1)
  );

  ahbl_sst26_xip_rd #(.SCK_DIV(3), .CS_HIGH_CYC(2)) dut3 (
    .HCLK(clk), .HRESETn(rstn), .bus(b3),
    .fsclk(fsclk3), .fcen(fcen3), .fdo(fdo3), .fdi(fdi3)
  );

  int cur;
  logic        cur_hready;
  logic [31:0] cur_hrdata;
  assign cur_hready = (cur == 1) ? b3.HREADYOUT : b1.HREADYOUT;
  assign cur_hrdata = (cur == 1) ? b3.HRDATA : b1.HRDATA;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    case (a)
      24'h000104: return 32'h0000_0513;
      24'h000000: return 32'hDEAD_BEEF;
      24'h000004: return 32'h1234_5678;
      default:    return 32'hA5A5_5A5A;
    endcase
  endfunction

  // Serial order on SO: B0 first, each byte MSB first.
  function automatic logic [31:0] so_seq(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Flash model for dut1: captures SI on rising SCK, presents SO for the high half.
  int cnt1 = 0, falls1 = 0;
  logic [31:0] fr1 = '0, seq1 = '0;
  logic [7:0]  cmd1 = '0;
  logic [23:0] adr1 = '0;
  initial fdi1 = 1'b0;
  always @(negedge fcen1) begin cnt1 = 0; falls1++; end
  always @(posedge fsclk1) if (!fcen1) begin
    if (cnt1 < 32) begin
      fr1 = {fr1[30:0], fdo1};
      if (cnt1 == 31) begin cmd1 = fr1[31:24]; adr1 = fr1[23:0]; seq1 = so_seq(flash_word(adr1)); end
    end else fdi1 = seq1[63-cnt1];
    cnt1++;
  end

  int cnt3 = 0, per3 = 0;
  time t3 = 0;
  logic [31:0] fr3 = '0, seq3 = '0;
  logic [7:0]  cmd3 = '0;
  logic [23:0] adr3 = '0;
  initial fdi3 = 1'b0;
  always @(negedge fcen3) cnt3 = 0;
  always @(posedge fsclk3) begin
    if (!fcen3) begin
      per3 = int'(($time - t3) / 10);
      if (cnt3 < 32) begin
        fr3 = {fr3[30:0], fdo3};
        if (cnt3 == 31) begin cmd3 = fr3[31:24]; adr3 = fr3[23:0]; seq3 = so_seq(flash_word(adr3)); end
      end else fdi3 = seq3[63-cnt3];
      cnt3++;
    end
    t3 = $time;
  end

  // Length of the most recent fcen-high interval of dut1, in HCLK cycles.
  int hi1 = 0, last_hi1 = 0;
  always @(negedge clk) begin
    if (fcen1 === 1'b1) hi1++;
    else if (hi1 != 0) begin last_hi1 = hi1; hi1 = 0; end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transfer: address phase, then wait out the data phase (bounded).
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      output int waits, output logic [31:0] d);
    if (cur == 1) sel3 = 1'b1; else sel1 = 1'b1;
    haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
    @(posedge clk); #1;
    sel1 = 1'b0; sel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    waits = 0;
    while (cur_hready !== 1'b1 && waits < 1000) begin
      @(posedge clk); #1;
      waits++;
    end
    d = cur_hrdata;
  endtask

  int w, f0;
  logic [31:0] d;

  initial begin
    rstn = 1'b0; sel1 = 1'b0; sel3 = 1'b0; haddr = '0; htrans = 2'b00;
    hsize = 3'd2; hwrite = 1'b0; cur = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_hreadyout", 32'(b1.HREADYOUT), 32'd1);
    check("rst_hrdata", b1.HRDATA, 32'h0);
    check("rst_hresp", 32'(b1.HRESP), 32'd0);
    check("rst_fcen", 32'(fcen1), 32'd1);
    check("rst_fsclk", 32'(fsclk1), 32'd0);
    check("rst_fdo", 32'(fdo1), 32'd0);
    rstn = 1'b1;
    idle(4);

    // First miss at 0x104
    xfer(32'h0000_0104, 1'b0, 3'd2, w, d);
    check("miss_waits", 32'(w), 32'd129);
    check("miss_data", d, 32'h0000_0513);
    check("miss_cmd", 32'(cmd1), 32'h03);
    check("miss_addr", 32'(adr1), 32'h000104);
    check("miss_sck_edges", 32'(cnt1), 32'd64);

    // Same word again: buffer hit
    f0 = falls1;
    xfer(32'h0000_0104, 1'b0, 3'd2, w, d);
    check("hit_waits", 32'(w), 32'd0);
    check("hit_data", d, 32'h0000_0513);
    idle(2);
    check("hit_no_fcen", 32'(falls1), 32'(f0));

    // Back-to-back misses: second one waits out the chip-select gap
    idle(4);
    xfer(32'h0000_0000, 1'b0, 3'd2, w, d);
    check("b2b0_waits", 32'(w), 32'd129);
    check("b2b0_data", d, 32'hDEAD_BEEF);
    check("b2b0_addr", 32'(adr1), 32'h000000);
    xfer(32'h0000_0004, 1'b0, 3'd2, w, d);
    check("b2b1_waits", 32'(w), 32'd131);
    check("b2b1_data", d, 32'h1234_5678);
    check("b2b1_addr", 32'(adr1), 32'h000004);
    check("b2b1_cmd", 32'(cmd1), 32'h03);
    check("b2b_gap_ge2", 32'(last_hi1 >= 2), 32'd1);

    // Byte read at 0x106 fetches the aligned word
    idle(4);
    xfer(32'h0000_0106, 1'b0, 3'd0, w, d);
    check("byte_waits", 32'(w), 32'd129);
    check("byte_data", d, 32'h0000_0513);
    check("byte_addr", 32'(adr1), 32'h000104);

    // Write: zero-wait OKAY, buffer untouched
    f0 = falls1;
    xfer(32'h0000_0104, 1'b1, 3'd2, w, d);
    check("wr_waits", 32'(w), 32'd0);
    check("wr_hresp", 32'(b1.HRESP), 32'd0);
    xfer(32'h0000_0104, 1'b0, 3'd2, w, d);
    check("wr_hit_waits", 32'(w), 32'd0);
    check("wr_hit_data", d, 32'h0000_0513);
    idle(2);
    check("wr_no_fcen", 32'(falls1), 32'(f0));

    // Reset during SHIFT bit 20
    idle(4);
    sel1 = 1'b1; haddr = 32'h0; htrans = 2'b10;
    @(posedge clk); #1;
    sel1 = 1'b0; htrans = 2'b00;
    for (int i = 0; i < 300 && cnt1 < 21; i++) begin @(posedge clk); #1; end
    check("abort_at_bit20", 32'(cnt1), 32'd21);
    rstn = 1'b0;
    #1;
    check("abort_fcen", 32'(fcen1), 32'd1);
    check("abort_fsclk", 32'(fsclk1), 32'd0);
    check("abort_hreadyout", 32'(b1.HREADYOUT), 32'd1);
    #3 rstn = 1'b1;
    idle(4);
    xfer(32'h0000_0104, 1'b0, 3'd2, w, d);
    check("refetch_waits", 32'(w), 32'd129);
    check("refetch_data", d, 32'h0000_0513);
    check("refetch_addr", 32'(adr1), 32'h000104);

    // SCK_DIV=3 slave
    cur = 1;
    idle(2);
    xfer(32'h0000_0000, 1'b0, 3'd2, w, d);
    check("div3_waits", 32'(w), 32'd385);
    check("div3_data", d, 32'hDEAD_BEEF);
    check("div3_cmd", 32'(cmd3), 32'h03);
    check("div3_addr", 32'(adr3), 32'h000000);
    check("div3_sck_period", 32'(per3), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
